ram_row_decoder_seq: RTL and testbench
======================================

// Module: ram_row_decoder_seq
// PURPOSE
//  Parametrised registered row decoder for the word-organised RAM arrays (default 32 rows).
//  - Converts a binary address plus read/write strobes into a one-hot row select and qualified strobes.
//  - Adds a built-in clear sequencer: walks every row, asserting write, so the array can be zeroed.
//  - Sits between the RAM controller and the storage rows.
//  - Replaces the combinational fixed-width decoders in the array path.
// PARAMETERS
//  ROWS    32             number of rows decoded (2..256, need not be a power of two)
//  ADDR_W  $clog2(ROWS)   address width (localparam, derived from ROWS)
// PORTS
//  clk       in   1       clock, all state updates on rising edge
//  rst_n     in   1       asynchronous active-low reset
//  en        in   1       access request for this cycle
//  addr      in   ADDR_W  row address of the access
//  we_in     in   1       write strobe of the access
//  re_in     in   1       read strobe of the access
//  clr_start in   1       request a full-array clear
//  clr_abort in   1       terminate a running clear
//  sel       out  ROWS    registered one-hot row select
//  we_out    out  1       registered write strobe to the array
//  re_out    out  1       registered read strobe to the array
//  clr_busy  out  1       clear sequence in progress
//  clr_done  out  1       one-cycle pulse: clear completed normally
//  addr_err  out  1       one-cycle pulse: access addressed a row >= ROWS
// BEHAVIOUR
//  Reset
//  - rst_n=0 forces immediately, independent of clk: state=IDLE, cnt=0, all outputs 0.
//  - Reset during a clear abandons it; clr_done is not pulsed.
//  State machine
//  - States: IDLE, CLEAR, DONE.
//  - All outputs are registered; access latency is exactly 1 cycle.
//  IDLE, per rising edge:
//  - en=1, addr<ROWS: sel<=1<<addr, we_out<=we_in, re_out<=re_in&~we_in (write wins if both high).
//  - en=1, addr>=ROWS: sel<=0, we_out<=0, re_out<=0, addr_err<=1 for one cycle.
//  - en=0: sel<=0, we_out<=0, re_out<=0.
//  - clr_start=1: has priority over en; the same-cycle access is dropped, with no addr_err.
//    On that edge: state<=CLEAR, sel<=one-hot(0), we_out<=1, re_out<=0, clr_busy<=1, cnt<=1.
//  CLEAR, per edge:
//  - If cnt<ROWS: sel<=1<<cnt, we_out<=1, cnt<=cnt+1.
//  - If cnt==ROWS: state<=DONE, sel<=0, we_out<=0, clr_busy<=0, clr_done<=1.
//  - Net effect: rows 0..ROWS-1 are each selected with we_out=1 for exactly one cycle, in
//    ascending order; clr_busy is high for exactly ROWS cycles.
//  - en, we_in, re_in and clr_start are ignored; addr_err stays 0.
//  - clr_abort=1: state<=IDLE, sel<=0, we_out<=0, clr_busy<=0, cnt<=0; no clr_done.
//  DONE:
//  - Lasts one cycle (clr_done high), then state<=IDLE and clr_done<=0.
//  - Inputs are ignored during DONE.
//  - clr_start is accepted again from the first IDLE cycle.
//  Width rules and invariants
//  - cnt is ADDR_W+1 bits wide so that cnt==ROWS is representable when ROWS is a power of two.
//  - sel is always one-hot or zero, never multi-hot.
//  - clr_abort has no effect outside CLEAR.
// TESTING
//  1. Reset, then en=1 addr=5 we_in=1 -> next cycle sel=32'h20, we_out=1, re_out=0.
//     Then en=0 -> sel=0, we_out=0.
//  2. en=1 addr=31 we_in=1 re_in=1 -> sel=32'h8000_0000, we_out=1, re_out=0.
//     With ROWS=24, addr=30 -> sel=0, addr_err=1 for one cycle.
//  3. clr_start pulse -> sel walks 0x1, 0x2 .. 0x8000_0000 over 32 cycles with we_out=1 and
//     clr_busy=1; then one cycle with clr_done=1 and sel=0; back to IDLE.
//  4. clr_start and en=1 addr=3 in the same cycle -> clear runs, row-3 access dropped, addr_err=0.
//     en pulses during the clear -> no effect on sel.
//  5. clr_abort at walk step 10 -> next cycle sel=0, clr_busy=0, clr_done never pulses.
//     A new clr_start restarts the walk from row 0.
//  6. rst_n=0 asynchronously at step 7 of a clear -> outputs 0 immediately, no clr_done.
//     After release, a normal access works with 1-cycle latency.

Source files
------------

// File: rtl/ram_row_decoder_seq.sv
// ram_row_decoder_seq: registered one-hot row decoder with a built-in array clear sequencer
module ram_row_decoder_seq #(
  parameter int ROWS = 32,
  localparam int ADDR_W = $clog2(ROWS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we_in,
  input  logic              re_in,
  input  logic              clr_start,
  input  logic              clr_abort,
  output logic [ROWS-1:0]   sel,
  output logic              we_out,
  output logic              re_out,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              addr_err
);
  localparam int CW = ADDR_W + 1;
  localparam logic [ROWS-1:0] ONE = ROWS'(1);
  localparam logic [1:0] S_IDLE = 2'd0, S_CLEAR = 2'd1, S_DONE = 2'd2;
  logic [1:0] state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [ROWS-1:0] sel_q, sel_d;
  logic we_q, we_d, re_q, re_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic in_range;
  // widened so the compare stays meaningful when ROWS is a power of two
  assign in_range = CW'(addr) < CW'(ROWS);
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    sel_d = '0;
    we_d = 1'b0;
    re_d = 1'b0;
    busy_d = 1'b0;
    done_d = 1'b0;
    err_d = 1'b0;
    case (state_q)
      S_IDLE:
        if (clr_start) begin
          state_d = S_CLEAR;
          sel_d = ONE;
          we_d = 1'b1;
          busy_d = 1'b1;
          cnt_d = CW'(1);
        end else if (en) begin
          if (in_range) begin
            sel_d = ONE << addr;
            we_d = we_in;
            re_d = re_in & ~we_in;
          end else err_d = 1'b1;
        end
      S_CLEAR:
        if (clr_abort) begin
          state_d = S_IDLE;
          cnt_d = '0;
        end else if (cnt_q < CW'(ROWS)) begin
          sel_d = ONE << cnt_q;
          we_d = 1'b1;
          busy_d = 1'b1;
          cnt_d = cnt_q + CW'(1);
        end else begin
          state_d = S_DONE;
          done_d = 1'b1;
          cnt_d = '0;
        end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      sel_q <= '0;
      we_q <= 1'b0;
      re_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      sel_q <= sel_d;
      we_q <= we_d;
      re_q <= re_d;
      busy_q <= busy_d;
      done_q <= done_d;
      err_q <= err_d;
    end
  end
  assign sel = sel_q;
  assign we_out = we_q;
  assign re_out = re_q;
  assign clr_busy = busy_q;
  assign clr_done = done_q;
  assign addr_err = err_q;
endmodule

// File: tb/tb_ram_row_decoder_seq.sv
// tb_ram_row_decoder_seq: directed checks of a 32-row and a 24-row decoder driven in parallel
module tb_ram_row_decoder_seq;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, we_in = 1'b0, re_in = 1'b0;
  logic clr_start = 1'b0, clr_abort = 1'b0;
  logic [4:0] addr = '0;
  logic [31:0] sel32;
  logic [23:0] sel24;
  logic we32, re32, busy32, done32, err32, we24, re24, busy24, done24, err24;
  logic [36:0] obs32, exp32;
  logic [28:0] obs24, exp24;
  int n_checks = 0, n_fail = 0;
  assign obs32 = {sel32, we32, re32, busy32, done32, err32};
  assign obs24 = {sel24, we24, re24, busy24, done24, err24};
  always #5 clk = ~clk;
  ram_row_decoder_seq #(.ROWS(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .en(en), .addr(addr), .we_in(we_in), .re_in(re_in),
    .clr_start(clr_start), .clr_abort(clr_abort), .sel(sel32), .we_out(we32),
    .re_out(re32), .clr_busy(busy32), .clr_done(done32), .addr_err(err32));
  ram_row_decoder_seq #(.ROWS(24)) dut24 (
    .clk(clk), .rst_n(rst_n), .en(en), .addr(addr), .we_in(we_in), .re_in(re_in),
    .clr_start(clr_start), .clr_abort(clr_abort), .sel(sel24), .we_out(we24),
    .re_out(re24), .clr_busy(busy24), .clr_done(done24), .addr_err(err24));
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic access(input logic e, input logic [4:0] a, input logic w, input logic r);
    en = e;
    addr = a;
    we_in = w;
    re_in = r;
  endtask
  task automatic test_reset;
    step();
    step();
    n_checks++;
    if (obs32 !== 37'd0) begin n_fail++; $display("FAIL reset32: got %h want 0", obs32); end
    n_checks++;
    if (obs24 !== 29'd0) begin n_fail++; $display("FAIL reset24: got %h want 0", obs24); end
    rst_n = 1'b1;
  endtask
  task automatic test_access;
    access(1, 5, 1, 0);
    step();
    exp32 = {32'h20, 5'b10000};
    n_checks++;
    if (obs32 !== exp32) begin n_fail++; $display("FAIL write_row5: got %h want %h", obs32, exp32); end
    access(1, 7, 0, 1);
    step();
    exp32 = {32'h80, 5'b01000};
    n_checks++;
    if (obs32 !== exp32) begin n_fail++; $display("FAIL read_row7: got %h want %h", obs32, exp32); end
    access(0, 7, 1, 1);
    step();
    n_checks++;
    if (obs32 !== 37'd0) begin n_fail++; $display("FAIL idle_en0: got %h want 0", obs32); end
  endtask
  task automatic test_boundary;
    access(1, 31, 1, 1);
    step();
    exp32 = {32'h8000_0000, 5'b10000};
    n_checks++;
    if (obs32 !== exp32) begin n_fail++; $display("FAIL row31_wins: got %h want %h", obs32, exp32); end
    exp24 = {24'h0, 5'b00001};
    n_checks++;
    if (obs24 !== exp24) begin n_fail++; $display("FAIL err24_a31: got %h want %h", obs24, exp24); end
    access(1, 23, 0, 1);
    step();
    exp24 = {24'h80_0000, 5'b01000};
    n_checks++;
    if (obs24 !== exp24) begin n_fail++; $display("FAIL row23_24: got %h want %h", obs24, exp24); end
    access(1, 24, 0, 1);
    step();
    exp24 = {24'h0, 5'b00001};
    n_checks++;
    if (obs24 !== exp24) begin n_fail++; $display("FAIL err24_a24: got %h want %h", obs24, exp24); end
    access(0, 0, 0, 0);
    step();
    n_checks++;
    if (obs24 !== 29'd0) begin n_fail++; $display("FAIL err_one_cycle: got %h want 0", obs24); end
  endtask
  task automatic test_clear;
    access(1, 3, 0, 1);
    clr_start = 1'b1;
    step();
    clr_start = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (i > 0) step();
      access((i % 2 == 1) && (i < 16), 3, 0, 1);
      exp32 = {32'h1 << i, 5'b10100};
      n_checks++;
      if (obs32 !== exp32) begin n_fail++; $display("FAIL walk32_%0d: got %h want %h", i, obs32, exp32); end
      exp24 = i < 24 ? {24'h1 << i, 5'b10100} : (i == 24 ? 29'b00010 : 29'd0);
      n_checks++;
      if (obs24 !== exp24) begin n_fail++; $display("FAIL walk24_%0d: got %h want %h", i, obs24, exp24); end
    end
    step();
    n_checks++;
    if (obs32 !== 37'b00010) begin n_fail++; $display("FAIL done32: got %h want 2", obs32); end
    step();
    n_checks++;
    if (obs32 !== 37'd0) begin n_fail++; $display("FAIL back_idle32: got %h want 0", obs32); end
    access(1, 3, 0, 1);
    step();
    exp32 = {32'h8, 5'b01000};
    n_checks++;
    if (obs32 !== exp32) begin n_fail++; $display("FAIL post_clear_access: got %h want %h", obs32, exp32); end
    access(0, 0, 0, 0);
    step();
  endtask
  task automatic test_abort;
    logic saw_done = 1'b0;
    clr_start = 1'b1;
    step();
    clr_start = 1'b0;
    for (int i = 0; i < 10; i++) step();
    exp32 = {32'h400, 5'b10100};
    n_checks++;
    if (obs32 !== exp32) begin n_fail++; $display("FAIL abort_step10: got %h want %h", obs32, exp32); end
    clr_abort = 1'b1;
    step();
    clr_abort = 1'b0;
    n_checks++;
    if (obs32 !== 37'd0) begin n_fail++; $display("FAIL aborted32: got %h want 0", obs32); end
    n_checks++;
    if (obs24 !== 29'd0) begin n_fail++; $display("FAIL aborted24: got %h want 0", obs24); end
    for (int i = 0; i < 40; i++) begin
      step();
      saw_done |= done32 | done24 | busy32;
    end
    n_checks++;
    if (saw_done !== 1'b0) begin n_fail++; $display("FAIL abort_no_done: got %b want 0", saw_done); end
    clr_start = 1'b1;
    step();
    clr_start = 1'b0;
    exp32 = {32'h1, 5'b10100};
    n_checks++;
    if (obs32 !== exp32) begin n_fail++; $display("FAIL restart_row0: got %h want %h", obs32, exp32); end
    clr_abort = 1'b1;
    step();
    access(1, 5, 1, 0);
    step();
    exp32 = {32'h20, 5'b10000};
    n_checks++;
    if (obs32 !== exp32) begin n_fail++; $display("FAIL abort_idle_noeffect: got %h want %h", obs32, exp32); end
    clr_abort = 1'b0;
    access(0, 0, 0, 0);
    step();
  endtask
  task automatic test_async_reset;
    clr_start = 1'b1;
    step();
    clr_start = 1'b0;
    for (int i = 0; i < 7; i++) step();
    exp32 = {32'h80, 5'b10100};
    n_checks++;
    if (obs32 !== exp32) begin n_fail++; $display("FAIL rst_step7: got %h want %h", obs32, exp32); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (obs32 !== 37'd0) begin n_fail++; $display("FAIL async_rst32: got %h want 0", obs32); end
    n_checks++;
    if (obs24 !== 29'd0) begin n_fail++; $display("FAIL async_rst24: got %h want 0", obs24); end
    step();
    step();
    rst_n = 1'b1;
    step();
    step();
    n_checks++;
    if (obs32 !== 37'd0) begin n_fail++; $display("FAIL rst_no_done: got %h want 0", obs32); end
    access(1, 5, 1, 0);
    step();
    exp32 = {32'h20, 5'b10000};
    n_checks++;
    if (obs32 !== exp32) begin n_fail++; $display("FAIL rst_then_access: got %h want %h", obs32, exp32); end
    access(0, 0, 0, 0);
  endtask
  initial begin
    test_reset();
    test_access();
    test_boundary();
    test_clear();
    test_abort();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
